// File: rtl/ext_bus_slave_bridge_if.sv
// MCU multiplexed external bus plus the demultiplexed target-side request, grouped as one bundle.
// slave = bridge view, master = MCU/target (bench) view.
interface ext_bus_slave_bridge_if;
  logic        ae;
  logic        ext_read;
  logic        ext_write;
  logic [15:0] ext_ad_out;
  logic [7:0]  ext_ad_in;
  logic        ext_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        off_sel;
  logic        io_sel;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        bus_error;

  modport slave (
    input  ae, ext_read, ext_write, ext_ad_out, mem_rdata, mem_ready,
    output ext_ad_in, ext_ready, mem_addr, mem_wdata, mem_read, mem_write,
           off_sel, io_sel, bus_error
  );

  modport master (
    output ae, ext_read, ext_write, ext_ad_out, mem_rdata, mem_ready,
    input  ext_ad_in, ext_ready, mem_addr, mem_wdata, mem_read, mem_write,
           off_sel, io_sel, bus_error
  );
endinterface

// File: rtl/ext_bus_slave_bridge.sv
// Demultiplexes the MCU AE/AD bus into a 32-bit address + byte request with IO/off-chip decode.
// Optional watchdog on the target access is enabled by defining BRIDGE_TIMEOUT_EN.
module ext_bus_slave_bridge #(
  parameter logic [11:0] IO_BASE_HI     = 12'h1A1,
  parameter logic [19:0] OFF_MIN_HI     = 20'h00001,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  ext_bus_slave_bridge_if.slave        bus
);

  typedef enum logic [2:0] {S_IDLE, S_AHI, S_CMD, S_ACC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        wtaken_q, wtaken_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic        io_hit, off_hit, miss;
  logic        timeout;

  assign io_hit  = (addr_q[31:20] == IO_BASE_HI) && (addr_q[19:17] == 3'b000);
  assign off_hit = (addr_q[31:12] >= OFF_MIN_HI) && !io_hit;
  assign miss    = !io_hit && !off_hit;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Last ACC cycle of the watchdog window: the edge leaving it lands in DONE.
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wtaken_d = wtaken_q;
    is_wr_d  = is_wr_q;
    err_d    = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.ae) begin
          addr_d[15:0] = bus.ext_ad_out;
          wtaken_d     = 1'b0;
          state_d      = S_AHI;
        end
      end
      S_AHI: begin
        // Dropping AE after only the low halfword abandons the cycle; the partial address stays.
        if (bus.ae) begin
          addr_d[31:16] = bus.ext_ad_out;
          state_d       = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus.ae) begin
          addr_d[15:0] = bus.ext_ad_out;
          wtaken_d     = 1'b0;
          state_d      = S_AHI;
        end else begin
          if (!wtaken_q) begin
            wdata_d  = bus.ext_ad_out[7:0];
            wtaken_d = 1'b1;
          end
          if (bus.ext_write || bus.ext_read) begin
            is_wr_d = bus.ext_write;
            rdata_d = 8'h00;
            if (miss) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ACC;
`ifdef BRIDGE_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
          end
        end
      end
      S_ACC: begin
        if (bus.mem_ready) begin
          if (!is_wr_q) rdata_d = bus.mem_rdata;
          state_d = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 8'hFF;
          state_d = S_DONE;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        if (!bus.ext_read && !bus.ext_write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wtaken_q <= 1'b0;
      is_wr_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wtaken_q <= wtaken_d;
      is_wr_q  <= is_wr_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = (state_q == S_ACC) && !is_wr_q;
  assign bus.mem_write = (state_q == S_ACC) && is_wr_q;
  assign bus.off_sel   = off_hit;
  assign bus.io_sel    = io_hit;
  assign bus.ext_ready = (state_q == S_DONE);
  assign bus.ext_ad_in = (state_q == S_DONE) ? rdata_q : 8'h00;
  assign bus.bus_error = err_q;

endmodule

// File: tb/tb_ext_bus_slave_bridge.sv
// Directed bench for ext_bus_slave_bridge: MCU bus driver, simple target model and a completion scoreboard.
module tb_ext_bus_slave_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_bus_slave_bridge_if bus();

  ext_bus_slave_bridge #(
    .IO_BASE_HI(12'h1A1),
    .OFF_MIN_HI(20'h00001),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two AE cycles: low halfword, then high halfword left on the bus for the next edge.
  task automatic addr_phase(input logic [31:0] a);
    cyc();
    bus.ae         = 1'b1;
    bus.ext_ad_out = a[15:0];
    cyc();
    bus.ext_ad_out = a[31:16];
  endtask

  // dly > 0: target raises mem_ready in its dly-th ACC cycle; dly < 0: target never answers.
  task automatic run_cmd(input string tag, input logic [31:0] a, input bit wr, input bit rd,
                         input logic [7:0] wd, input logic [7:0] trd, input int dly,
                         input bit e_off, input bit e_io);
    exp_t e, g;
    bit   miss, done;
    int   n, lat, e_lat;
    miss = !e_off && !e_io;
    cyc();
    bus.ae         = 1'b0;
    bus.ext_ad_out = {8'hEE, wd};
    bus.ext_write  = wr;
    bus.ext_read   = rd;
    e.err   = miss;
    e.rdata = (miss || wr) ? 8'h00 : trd;
    e_lat   = miss ? 1 : dly + 1;
    if (!miss && dly < 0) begin
      e.err   = 1'b1;
      e.rdata = 8'hFF;
      e_lat   = 17;
    end
    sb.push_back(e);
    n = 0; lat = 0; done = 0;
    while (!done && lat < 60) begin
      cyc();
      lat++;
      bus.mem_ready = 1'b0;
      if (bus.ext_ready) begin
        g = sb.pop_front();
        chk({tag, " ext_ad_in"}, {24'h0, bus.ext_ad_in}, {24'h0, g.rdata});
        chk({tag, " bus_error"}, {31'h0, bus.bus_error}, {31'h0, g.err});
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " mem_addr"}, bus.mem_addr, a);
        chk({tag, " off_sel"}, {31'h0, bus.off_sel}, {31'h0, e_off});
        chk({tag, " io_sel"}, {31'h0, bus.io_sel}, {31'h0, e_io});
        chk({tag, " req dropped"}, {31'h0, bus.mem_read | bus.mem_write}, 32'h0);
        done = 1;
      end else if (bus.mem_read || bus.mem_write) begin
        n++;
        if (n == 1) begin
          chk({tag, " mem_write"}, {31'h0, bus.mem_write}, {31'h0, wr});
          chk({tag, " mem_read"}, {31'h0, bus.mem_read}, {31'h0, rd && !wr});
          chk({tag, " mem_wdata"}, {24'h0, bus.mem_wdata}, {24'h0, wd});
        end
        if (dly > 0 && n >= dly) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = trd;
        end
      end
    end
    if (!done) chk({tag, " no ext_ready within bound"}, 32'h0, 32'h1);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    cyc();
    chk({tag, " ready held"}, {31'h0, bus.ext_ready}, 32'h1);
    chk({tag, " error pulse ends"}, {31'h0, bus.bus_error}, 32'h0);
    bus.ext_read  = 1'b0;
    bus.ext_write = 1'b0;
    cyc();
    chk({tag, " ready released"}, {31'h0, bus.ext_ready}, 32'h0);
    chk({tag, " ad_in released"}, {24'h0, bus.ext_ad_in}, 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.ae         = 1'b0;
    bus.ext_read   = 1'b0;
    bus.ext_write  = 1'b0;
    bus.ext_ad_out = 16'h0000;
    bus.mem_rdata  = 8'h00;
    bus.mem_ready  = 1'b0;
    #3;
    chk("rst ext_ready", {31'h0, bus.ext_ready}, 32'h0);
    chk("rst ext_ad_in", {24'h0, bus.ext_ad_in}, 32'h0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_wdata", {24'h0, bus.mem_wdata}, 32'h0);
    chk("rst mem_read", {31'h0, bus.mem_read}, 32'h0);
    chk("rst mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rst off_sel", {31'h0, bus.off_sel}, 32'h0);
    chk("rst io_sel", {31'h0, bus.io_sel}, 32'h0);
    chk("rst bus_error", {31'h0, bus.bus_error}, 32'h0);
    #9 rst = 1'b0;

    // Decode miss, then the same write into off-chip space
    addr_phase(32'h00000040);
    run_cmd("wr miss", 32'h00000040, 1'b1, 1'b0, 8'hA5, 8'h00, 3, 1'b0, 1'b0);
    addr_phase(32'h00002040);
    run_cmd("wr off", 32'h00002040, 1'b1, 1'b0, 8'hA5, 8'h00, 3, 1'b1, 1'b0);
    addr_phase(32'h00003000);
    run_cmd("rd off", 32'h00003000, 1'b0, 1'b1, 8'h00, 8'h5C, 2, 1'b1, 1'b0);
    addr_phase(32'h1A100010);
    run_cmd("rd io", 32'h1A100010, 1'b0, 1'b1, 8'h00, 8'h3C, 1, 1'b0, 1'b1);
    addr_phase(32'h1A120000);
    run_cmd("rd 1A12", 32'h1A120000, 1'b0, 1'b1, 8'h00, 8'h77, 1, 1'b1, 1'b0);
    addr_phase(32'h1A1FFFFF);
    run_cmd("rd 1A1F", 32'h1A1FFFFF, 1'b0, 1'b1, 8'h00, 8'hC3, 1, 1'b1, 1'b0);
    addr_phase(32'h00001000);
    run_cmd("wr 1000", 32'h00001000, 1'b1, 1'b0, 8'h81, 8'h00, 1, 1'b1, 1'b0);
    addr_phase(32'h00000FFF);
    run_cmd("rd 0FFF", 32'h00000FFF, 1'b0, 1'b1, 8'h00, 8'h42, 1, 1'b0, 1'b0);
    addr_phase(32'h00005000);
    run_cmd("wr+rd", 32'h00005000, 1'b1, 1'b1, 8'h3E, 8'h11, 1, 1'b1, 1'b0);

    // Abort after the low halfword only
    cyc();
    bus.ae         = 1'b1;
    bus.ext_ad_out = 16'h5A5A;
    cyc();
    bus.ae = 1'b0;
    cyc();
    chk("abort no req", {31'h0, bus.mem_read | bus.mem_write}, 32'h0);
    chk("abort no ready", {31'h0, bus.ext_ready}, 32'h0);
    chk("abort partial addr", {16'h0, bus.mem_addr[15:0]}, 32'h5A5A);
    cyc();
    chk("abort idle", {31'h0, bus.mem_read | bus.mem_write | bus.ext_ready}, 32'h0);

    // AE re-asserted in CMD replaces the address
    addr_phase(32'h1A100000);
    addr_phase(32'h00002080);
    run_cmd("restart", 32'h00002080, 1'b1, 1'b0, 8'h6D, 8'h00, 2, 1'b1, 1'b0);

    // Asynchronous reset while a read is outstanding
    addr_phase(32'h00004000);
    cyc();
    bus.ae         = 1'b0;
    bus.ext_ad_out = 16'h0000;
    bus.ext_read   = 1'b1;
    cyc();
    chk("pre-rst mem_read", {31'h0, bus.mem_read}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst mid mem_read", {31'h0, bus.mem_read}, 32'h0);
    chk("rst mid ext_ready", {31'h0, bus.ext_ready}, 32'h0);
    chk("rst mid mem_addr", bus.mem_addr, 32'h0);
    bus.ext_read = 1'b0;
    cyc();
    rst = 1'b0;
    addr_phase(32'h00004000);
    run_cmd("after rst", 32'h00004000, 1'b0, 1'b1, 8'h00, 8'h99, 2, 1'b1, 1'b0);

`ifdef BRIDGE_TIMEOUT_EN
    addr_phase(32'h00006000);
    run_cmd("timeout", 32'h00006000, 1'b0, 1'b1, 8'h00, 8'h00, -1, 1'b1, 1'b0);
`endif

    chk("scoreboard empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ext_bus_slave_bridge.md
Name: ext_bus_slave_bridge

Overview:
Board-side bridge that consumes the MCU external multiplexed address/data bus (AE, EXT_AD_OUT, EXT_READ, EXT_WRITE) and produces a demultiplexed 32-bit memory/IO request with a byte data path. It sits directly downstream of the MCU external bus master and upstream of the off-chip memory model or peripheral targets. It returns read data and EXT_READY to the MCU. It replaces ad-hoc bus latching in benches and board tops.

Parameters:
IO_BASE_HI, 12'h1A1, value compared against addr[31:20] for IO-region decode
OFF_MIN_HI, 20'h00001, addr[31:12] at or above this (and not IO) selects off-chip memory
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with BRIDGE_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ae  input  1  address enable from MCU
ext_read  input  1  MCU read strobe (level)
ext_write  input  1  MCU write strobe (level)
ext_ad_out  input  16  multiplexed address halfword / write data (bits 7:0)
ext_ad_in  output  8  read data to MCU; 8'h00 whenever ext_ready=0
ext_ready  output  1  access complete to MCU
mem_addr  output  32  latched full address
mem_wdata  output  8  latched write byte
mem_read  output  1  read request to selected target
mem_write  output  1  write request to selected target
off_sel  output  1  off-chip memory region selected
io_sel  output  1  IO region selected
mem_rdata  input  8  target read data, valid with mem_ready
mem_ready  input  1  target completion (level or pulse)
bus_error  output  1  one-cycle pulse on decode miss or timeout

Behaviour:
- Reset: state IDLE; mem_addr=0, mem_wdata=0, read-data register=0; all outputs 0.
- Decode (combinational from mem_addr): io_sel = (addr[31:20]==IO_BASE_HI) & (addr[19:17]==0). off_sel = (addr[31:12]>=OFF_MIN_HI) & ~io_sel. Miss = neither selected.
- IDLE: on ae=1, capture mem_addr[15:0]=ext_ad_out, go AHI.
- AHI: ae=1: capture mem_addr[31:16]=ext_ad_out, go CMD. ae=0: abort (partial address kept, no access), go IDLE.
- CMD: first clk with ae=0 captures mem_wdata=ext_ad_out[7:0] (once per address phase). ae=1 again: restart; capture new addr[15:0], go AHI. ext_write=1 (priority over ext_read when both asserted) or ext_read=1: on a miss, pulse bus_error and go DONE with read data 8'h00. Otherwise go ACC.
- ACC: mem_write or mem_read held high (exactly one) while in ACC, qualified by the latched command. mem_addr and mem_wdata stable throughout. On mem_ready=1: capture mem_rdata (reads only), drop request next cycle, go DONE. Minimum latency from command to ext_ready: 2 clk when the target is ready in its first ACC cycle.
- DONE: ext_ready=1, ext_ad_in=read-data register. Hold until ext_read=0 and ext_write=0, then go IDLE with ext_ready=0 in the same edge.
- ae=1 outside IDLE/AHI/CMD: ignored.
- Reset mid-access: immediate return to IDLE, request dropped, no ready.
- Back-to-back accesses: the next ae is accepted the cycle after DONE exits.

Optional Feature:
- BRIDGE_TIMEOUT_EN defined: a counter runs in ACC. When it reaches TIMEOUT_CYCLES without mem_ready, the request is dropped, bus_error pulses, read data is forced to 8'hFF, and the bridge goes DONE. The counter clears on ACC entry.
- Not defined: ACC waits indefinitely; no counter logic. bus_error is produced only by decode miss.

Test Plan:
- Off-chip write: ae 2 cycles with ext_ad_out 16'h0040 then 16'h0000, ae low with ext_ad_out 16'h00A5, ext_write=1, mem_ready after 3 cycles -> mem_addr=32'h00000040? No: this is a miss (addr[31:12]=0), so bus_error pulses and ext_ready=1, ext_ad_in=00. Repeat with address words 16'h2040 then 16'h0000 -> mem_addr=32'h00002040, off_sel=1, mem_write=1, mem_wdata=A5; ext_ready one cycle after mem_ready.
- Off-chip read 32'h00003000: mem_rdata=8'h5C with mem_ready -> ext_ad_in=5C while ext_ready=1, returns to 00 after ext_read falls.
- IO read 32'h1A100010 -> io_sel=1, off_sel=0. Address 32'h1A120000 -> off_sel=1, io_sel=0.
- Abort and restart: ae high for 1 cycle only, then low -> no request, state IDLE. ae re-asserted during CMD -> new address latched, old one discarded.
- rst pulsed during ACC with mem_read=1 -> mem_read=0, ext_ready=0 immediately; next transaction completes normally.
- With BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, target never ready -> after 16 ACC cycles bus_error pulses, ext_ready=1, ext_ad_in=FF.
